// File: rtl/alu_operand_seq.sv
// alu_operand_seq: collects two 4-bit operands and a 3-bit opcode from
// switches, one debounced push-button press per field, and presents them to
// an ALU as a complete operation.
//
// Flow: btn -> 2-flop synchronizer -> debouncer -> rising-edge press pulse
//       -> operand FSM (S_A -> S_B -> S_OP -> S_SHOW -> S_A).
//
// Handshake: there is no back-pressure. valid is a level, high exactly while
// the FSM sits in S_SHOW, and a/b/op are stable for as long as valid is high.
// The consumer may sample them on any cycle where valid is 1.
module alu_operand_seq #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  input  logic [3:0] sw,
  input  logic [2:0] op_sw,
  input  logic       clr,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [2:0] op,
  output logic       valid,
  output logic [1:0] state,
  output logic [7:0] ops_done
);

  // One spare bit above clog2 so the counter can hold DEBOUNCE_CYCLES-1
  // for every legal value, including DEBOUNCE_CYCLES == 1.
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_OP   = 2'b10,
    S_SHOW = 2'b11
  } state_t;

  // Input conditioning
  logic          sync_1;
  logic          btn_sync;
  logic          btn_db;
  logic          btn_db_d;
  logic [CW-1:0] db_cnt;
  logic          press;

  // Operand FSM and datapath registers
  state_t     state_r;
  state_t     state_next;
  logic [3:0] a_r;
  logic [3:0] a_next;
  logic [3:0] b_r;
  logic [3:0] b_next;
  logic [2:0] op_r;
  logic [2:0] op_next;
  logic       valid_r;
  logic       valid_next;
  logic [7:0] ops_r;
  logic [7:0] ops_next;

  // Two-flop synchronizer for the asynchronous button; only btn_sync is used.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_1   <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      sync_1   <= btn;
      btn_sync <= sync_1;
    end
  end

  // Debouncer: btn_db follows btn_sync only after it has differed for
  // DEBOUNCE_CYCLES consecutive cycles; any return to agreement restarts it.
  // clr deliberately does not touch this logic.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_cnt   <= '0;
      btn_db   <= 1'b0;
      btn_db_d <= 1'b0;
    end else begin
      btn_db_d <= btn_db;
      if (btn_sync == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == CNT_LAST) begin
        btn_db <= btn_sync;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Press is the single-cycle rising edge of the debounced level; a release
  // produces nothing, so holding the button yields exactly one press.
  assign press = btn_db & ~btn_db_d;

  // Next-state and datapath update; clr outranks a coincident press.
  always_comb begin
    state_next = state_r;
    a_next     = a_r;
    b_next     = b_r;
    op_next    = op_r;
    valid_next = valid_r;
    ops_next   = ops_r;
    if (clr) begin
      state_next = S_A;
      a_next     = 4'd0;
      b_next     = 4'd0;
      op_next    = 3'd0;
      valid_next = 1'b0;
      ops_next   = 8'd0;
    end else if (press) begin
      unique case (state_r)
        S_A: begin
          a_next     = sw;
          state_next = S_B;
        end
        S_B: begin
          b_next     = sw;
          state_next = S_OP;
        end
        S_OP: begin
          op_next    = op_sw;
          valid_next = 1'b1;
          ops_next   = ops_r + 8'd1;
          state_next = S_SHOW;
        end
        S_SHOW: begin
          valid_next = 1'b0;
          state_next = S_A;
        end
        default: begin
          state_next = S_A;
        end
      endcase
    end
  end

  // State and datapath registers; reset outranks clr and press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_A;
      a_r     <= 4'd0;
      b_r     <= 4'd0;
      op_r    <= 3'd0;
      valid_r <= 1'b0;
      ops_r   <= 8'd0;
    end else begin
      state_r <= state_next;
      a_r     <= a_next;
      b_r     <= b_next;
      op_r    <= op_next;
      valid_r <= valid_next;
      ops_r   <= ops_next;
    end
  end

  assign a        = a_r;
  assign b        = b_r;
  assign op       = op_r;
  assign valid    = valid_r;
  assign state    = state_r;
  assign ops_done = ops_r;

endmodule

// File: tb/tb_alu_operand_seq.sv
// Directed testbench for alu_operand_seq with DEBOUNCE_CYCLES = 4.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_alu_operand_seq;

  localparam int D = 4;

  logic       clk;
  logic       rst_n;
  logic       btn;
  logic [3:0] sw;
  logic [2:0] op_sw;
  logic       clr;
  logic [3:0] a;
  logic [3:0] b;
  logic [2:0] op;
  logic       valid;
  logic [1:0] state;
  logic [7:0] ops_done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  alu_operand_seq #(.DEBOUNCE_CYCLES(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn      (btn),
    .sw       (sw),
    .op_sw    (op_sw),
    .clr      (clr),
    .a        (a),
    .b        (b),
    .op       (op),
    .valid    (valid),
    .state    (state),
    .ops_done (ops_done)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag, input logic [1:0] e_state,
                           input logic [3:0] e_a, input logic [3:0] e_b,
                           input logic [2:0] e_op, input logic e_valid,
                           input logic [7:0] e_ops);
    check({tag, ".state"}, {6'd0, state}, {6'd0, e_state});
    check({tag, ".a"},     {4'd0, a},     {4'd0, e_a});
    check({tag, ".b"},     {4'd0, b},     {4'd0, e_b});
    check({tag, ".op"},    {5'd0, op},    {5'd0, e_op});
    check({tag, ".valid"}, {7'd0, valid}, {7'd0, e_valid});
    check({tag, ".ops"},   ops_done,      e_ops);
  endtask

  // Clean press: long enough high for one accepted press, long enough low
  // for the release to be accepted before the next press.
  task automatic press_btn();
    btn = 1'b1;
    tick(D + 4);
    btn = 1'b0;
    tick(D + 4);
  endtask

  initial begin
    rst_n = 1'b0;
    btn   = 1'b0;
    sw    = 4'd0;
    op_sw = 3'd0;
    clr   = 1'b0;
    tick(3);
    check_all("reset", 2'b00, 4'h0, 4'h0, 3'd0, 1'b0, 8'd0);

    // Latency: btn high from before edge 1, a updates at edge D+3 = 7.
    rst_n = 1'b1;
    btn   = 1'b1;
    sw    = 4'b0101;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      check($sformatf("lat_e%0d.state", k), {6'd0, state}, 8'h00);
      check($sformatf("lat_e%0d.a", k),     {4'd0, a},     8'h00);
    end
    tick(1);
    check("lat_e7.a",     {4'd0, a},     8'h05);
    check("lat_e7.state", {6'd0, state}, 8'h01);
    // Holding the button must not produce a second press.
    tick(12);
    check("hold.state", {6'd0, state}, 8'h01);
    check("hold.b",     {4'd0, b},     8'h00);
    btn = 1'b0;
    tick(D + 4);

    // Clear back to S_A, then one full operation.
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check_all("clr1", 2'b00, 4'h0, 4'h0, 3'd0, 1'b0, 8'd0);
    sw = 4'b0011;
    press_btn();
    sw = 4'b0100;
    press_btn();
    op_sw = 3'b000;
    press_btn();
    check_all("op1", 2'b11, 4'h3, 4'h4, 3'd0, 1'b1, 8'd1);
    // Switch changes without a press do nothing.
    sw    = 4'b1001;
    op_sw = 3'b101;
    tick(10);
    check_all("sw_nopress", 2'b11, 4'h3, 4'h4, 3'd0, 1'b1, 8'd1);
    press_btn();
    check_all("show_exit", 2'b00, 4'h3, 4'h4, 3'd0, 1'b0, 8'd1);

    // Glitches of 3 cycles with 2-cycle gaps never get through.
    for (int g = 0; g < 10; g++) begin
      btn = 1'b1;
      tick(3);
      btn = 1'b0;
      tick(2);
    end
    tick(D + 4);
    check_all("glitch", 2'b00, 4'h3, 4'h4, 3'd0, 1'b0, 8'd1);

    // Wrap of ops_done: clear, 255 complete sequences, then one more.
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    for (int s = 0; s < 255; s++) begin
      sw = 4'(s);
      press_btn();
      press_btn();
      press_btn();
      press_btn();
    end
    check("preload.ops",   ops_done,      8'd255);
    check("preload.state", {6'd0, state}, 8'h00);
    sw = 4'hA;
    press_btn();
    sw = 4'h6;
    press_btn();
    op_sw = 3'b101;
    press_btn();
    check_all("wrap", 2'b11, 4'hA, 4'h6, 3'b101, 1'b1, 8'd0);

    // clr coincident with a press event in S_OP.
    press_btn();
    sw = 4'h2;
    press_btn();
    sw = 4'h7;
    press_btn();
    check_all("pre_clr_sop", 2'b10, 4'h2, 4'h7, 3'b101, 1'b0, 8'd0);
    op_sw = 3'b011;
    btn = 1'b1;
    tick(D + 2);
    check("sop_before_press.state", {6'd0, state}, 8'h02);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check_all("clr_press", 2'b00, 4'h0, 4'h0, 3'd0, 1'b0, 8'd0);
    tick(10);
    check("clr_press_hold.state", {6'd0, state}, 8'h00);
    btn = 1'b0;
    tick(D + 4);

    // Reset mid-sequence in S_B with btn held high.
    sw = 4'h7;
    press_btn();
    check("pre_rst.state", {6'd0, state}, 8'h01);
    check("pre_rst.a",     {4'd0, a},     8'h07);
    btn = 1'b1;
    tick(3);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    sw    = 4'hC;
    check_all("rst_mid", 2'b00, 4'h0, 4'h0, 3'd0, 1'b0, 8'd0);
    tick(D + 2);
    check("rst_e6.state", {6'd0, state}, 8'h00);
    tick(1);
    check("rst_e7.a",     {4'd0, a},     8'h0C);
    check("rst_e7.state", {6'd0, state}, 8'h01);
    btn = 1'b0;
    tick(D + 4);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_operand_seq.md
ALU_OPERAND_SEQ -- requirements
Module: alu_operand_seq

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, giving the consecutive stable cycles (minimum 1) required to accept a button level change.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-004 The block SHALL have port btn, input, 1, raw asynchronous push-button, active-high, may bounce.
REQ-005 The block SHALL have port sw, input, 4, operand switches.
REQ-006 The block SHALL have port op_sw, input, 3, opcode switches (000 add ... 111 eq, matching the ALU op encoding).
REQ-007 The block SHALL have port clr, input, 1, synchronous clear of operand state, active-high.
REQ-008 The block SHALL have port a, output, 4, latched operand A to the ALU.
REQ-009 The block SHALL have port b, output, 4, latched operand B to the ALU.
REQ-010 The block SHALL have port op, output, 3, latched opcode to the ALU.
REQ-011 The block SHALL have port valid, output, 1, high while a, b and op form a complete operation.
REQ-012 The block SHALL have port state, output, 2, current FSM state (00 S_A, 01 S_B, 10 S_OP, 11 S_SHOW).
REQ-013 The block SHALL have port ops_done, output, 8, count of completed operations.

Function
REQ-014 btn SHALL pass through a 2-flop synchronizer; only the second flop (btn_sync) is used further.
REQ-015 Debounce: counter SHALL reset to 0 whenever btn_sync equals debounced level btn_db, else increment; when it equals DEBOUNCE_CYCLES-1 while differing, btn_db SHALL take btn_sync and counter SHALL return to 0.
REQ-016 Counter width SHALL be clog2(DEBOUNCE_CYCLES)+1 bits; no overflow for any legal parameter.
REQ-017 A press event SHALL be a single-cycle pulse, btn_db high and its one-cycle-delayed copy low; release SHALL produce no event.
REQ-018 Pulses on btn shorter than DEBOUNCE_CYCLES cycles at btn_sync SHALL never change btn_db.
REQ-019 On a press event: S_A latches a<=sw, goes S_B; S_B latches b<=sw, goes S_OP; S_OP latches op<=op_sw, sets valid, increments ops_done, goes S_SHOW; S_SHOW clears valid, goes S_A.
REQ-020 a, b, op SHALL hold their values until overwritten by a later press in the matching state or cleared; switch changes without a press SHALL have no effect.
REQ-021 Without a press event, state and all outputs SHALL hold.
REQ-022 Latency: btn stable high from before edge 1 SHALL update the targeted register at edge DEBOUNCE_CYCLES+3.
REQ-023 ops_done SHALL wrap 255 -> 0 without any other side effect.
REQ-024 clr high at an edge SHALL force state S_A, valid 0, a/b/op/ops_done 0; synchronizer and debounce state SHALL continue unaffected.
REQ-025 clr and a press event in the same cycle: clr SHALL win and the press SHALL be discarded.
REQ-026 Holding btn high SHALL yield exactly one press; a new press requires release accepted by debounce first.

Reset
REQ-027 rst_n low at an edge SHALL set state S_A, a/b/op 0, valid 0, ops_done 0, synchronizer flops 0, btn_db 0, counter 0; rst_n has priority over clr and press.
REQ-028 Reset asserted mid-sequence (any state, mid-debounce) SHALL discard partial operands; btn held high across reset release SHALL be accepted as a new press after debounce.

Verification
REQ-029 D=4; btn high from edge 1, sw=0101 -> a=0101, state=01 after edge 7; no change at edges 1-6.
REQ-030 Three clean presses with sw=0011, sw=0100, op_sw=000 -> a=0011, b=0100, op=000, valid=1, state=11, ops_done=1; fourth press -> valid=0, state=00, a/b/op retained.
REQ-031 D=4; 3-cycle btn glitches repeated 10 times, gaps of 2 cycles -> state stays 00, a unchanged.
REQ-032 Preload ops_done=255 via 255 full sequences; one more -> ops_done=0, valid=1.
REQ-033 In S_OP, clr and press event coincident -> state=00, valid=0, a=b=op=0, ops_done=0.
REQ-034 rst_n low for 1 cycle while in S_B with btn held high -> outputs zero, state 00; after D+3 edges past release, a=sw, state=01.
